// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/register widths, instruction field positions, NOP encoding.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned REG_W  = 3;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS2_LSB = 6;
  localparam int unsigned RS1_LSB = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_t;

  localparam word_t NOP_INSTR = 16'h0000;

  function automatic reg_t rs1_of(input word_t instr);
    return instr[RS1_LSB +: REG_W];
  endfunction

  function automatic reg_t rs2_of(input word_t instr);
    return instr[RS2_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the instruction in decode reads a register a load in EX is writing.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic id_valid_i,
  input  reg_t id_rs1_i,
  input  reg_t id_rs2_i,
  input  logic ex_mem_read_i,
  input  reg_t ex_rd_i,
  output logic hazard_o
);

  assign hazard_o = id_valid_i && ex_mem_read_i &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipe_if_id.sv
// IF/ID pipeline register with PC, load-use stall, flush and a saturating stall counter.
module pipe_if_id
  import cpu_pkg::*;
#(
  parameter word_t PC_RESET  = 16'h0000,
  parameter word_t NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next,
  input  logic [15:0] if_instr,
  input  logic        flush,
  input  logic        ext_stall,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_rd,
  output logic [15:0] pc_q,
  output logic [15:0] id_pc,
  output logic [15:0] id_instr,
  output logic        id_valid,
  output logic        id_bubble,
  output logic        hazard_stall,
  output logic [15:0] stall_count
);

  localparam word_t CNT_MAX = 16'hFFFF;

  word_t pc_d;
  word_t id_pc_q, id_pc_d;
  word_t id_instr_q, id_instr_d;
  logic  id_valid_q, id_valid_d;
  word_t stall_cnt_q, stall_cnt_d;
  logic  hold;

  hazard_detect u_hazard (
    .id_valid_i    (id_valid_q),
    .id_rs1_i      (rs1_of(id_instr_q)),
    .id_rs2_i      (rs2_of(id_instr_q)),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .hazard_o      (hazard_stall)
  );

  assign hold = hazard_stall || ext_stall;

  // Per-cycle action, priority FLUSH > HOLD > ADVANCE.
  always_comb begin
    pc_d        = pc_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      pc_d       = pc_next;
      id_pc_d    = pc_q;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (hold) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + WORD_W'(1);
      end
    end else begin
      pc_d       = pc_next;
      id_pc_d    = pc_q;
      id_instr_d = if_instr;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= PC_RESET;
      id_pc_q     <= '0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_valid    = id_valid_q;
  assign id_bubble   = !id_valid_q || hazard_stall;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_if_id.sv
// Scoreboard bench for pipe_if_id: directed per-cycle vectors queue their expected results.
module tb_pipe_if_id;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_next;
  logic [15:0] if_instr;
  logic        flush;
  logic        ext_stall;
  logic        ex_mem_read;
  logic [2:0]  ex_rd;
  logic [15:0] pc_q;
  logic [15:0] id_pc;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        id_bubble;
  logic        hazard_stall;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  // hz/bub are the combinational outputs before the edge; the rest are register values after it.
  typedef struct {
    logic        hz;
    logic        bub;
    logic [15:0] pc;
    logic [15:0] idpc;
    logic [15:0] instr;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  pipe_if_id #(.PC_RESET(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_next      (pc_next),
    .if_instr     (if_instr),
    .flush        (flush),
    .ext_stall    (ext_stall),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .pc_q         (pc_q),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .id_bubble    (id_bubble),
    .hazard_stall (hazard_stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic es, input logic mr,
                      input logic [2:0] rd, input logic [15:0] pn, input logic [15:0] ins,
                      input logic ehz, input logic ebub, input logic [15:0] epc,
                      input logic [15:0] eidpc, input logic [15:0] einstr,
                      input logic ev, input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst_n = r; flush = f; ext_stall = es; ex_mem_read = mr; ex_rd = rd;
    pc_next = pn; if_instr = ins;
    e.hz = ehz; e.bub = ebub; e.pc = epc; e.idpc = eidpc;
    e.instr = einstr; e.valid = ev; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compares combinational outputs just before the edge, registers just after.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hazard_stall", 16'(hazard_stall), 16'(e.hz));
        chk("id_bubble",    16'(id_bubble),    16'(e.bub));
        @(posedge clk);
        #1;
        chk("pc_q",        pc_q,            e.pc);
        chk("id_pc",       id_pc,           e.idpc);
        chk("id_instr",    id_instr,        e.instr);
        chk("id_valid",    16'(id_valid),   16'(e.valid));
        chk("stall_count", stall_count,     e.cnt);
      end
    end
  end

  initial begin
    logic [15:0] cnt;
    rst_n = 1'b0; flush = 1'b1; ext_stall = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd0;
    pc_next = 16'h1234; if_instr = 16'hABCD;
    // Reset wins over flush/stall/load in the same cycle.
    step(0,1,1,1,3'd0,16'h1234,16'hABCD, 0,1, 16'h0000,16'h0000,16'h0000,0,16'd0);
    // Sequential fetch: pc 0,2,4,6, id_pc trails by one edge.
    step(1,0,0,0,3'd0,16'h0002,16'h1000, 0,1, 16'h0002,16'h0000,16'h1000,1,16'd0);
    step(1,0,0,0,3'd0,16'h0004,16'h2000, 0,0, 16'h0004,16'h0002,16'h2000,1,16'd0);
    step(1,0,0,0,3'd0,16'h0006,16'h1058, 0,0, 16'h0006,16'h0004,16'h1058,1,16'd0);
    // Load-use on rs1 (0x1058 rs1=3): hold one cycle, then advance.
    step(1,0,0,1,3'd3,16'h0008,16'h3040, 1,1, 16'h0006,16'h0004,16'h1058,1,16'd1);
    step(1,0,0,0,3'd3,16'h0008,16'h3040, 0,0, 16'h0008,16'h0006,16'h3040,1,16'd1);
    // Load-use on rs2 (0x3040 rs2=1).
    step(1,0,0,1,3'd1,16'h000A,16'h4000, 1,1, 16'h0008,16'h0006,16'h3040,1,16'd2);
    // Load to an unrelated register: no hazard.
    step(1,0,0,1,3'd5,16'h000A,16'h4000, 0,0, 16'h000A,16'h0008,16'h4000,1,16'd2);
    // External stall holds and counts.
    step(1,0,1,0,3'd0,16'h000C,16'h5000, 0,0, 16'h000A,16'h0008,16'h4000,1,16'd3);
    // Flush to 0x0040.
    step(1,1,0,0,3'd0,16'h0040,16'h6000, 0,0, 16'h0040,16'h000A,16'h0000,0,16'd3);
    step(1,0,0,0,3'd0,16'h0042,16'h1058, 0,1, 16'h0042,16'h0040,16'h1058,1,16'd3);
    // Flush + ext_stall + hazard together: flush wins, counter unchanged.
    step(1,1,1,1,3'd3,16'h0080,16'h6000, 1,1, 16'h0080,16'h0042,16'h0000,0,16'd3);
    // Invalid decode slot never raises a hazard even if registers match.
    step(1,0,0,1,3'd0,16'hFFFE,16'h7000, 0,1, 16'hFFFE,16'h0080,16'h7000,1,16'd3);
    // PC wrap from 0xFFFE to 0x0000.
    step(1,0,0,0,3'd0,16'h0000,16'h8000, 0,0, 16'h0000,16'hFFFE,16'h8000,1,16'd3);
    // Long external stall saturates the counter.
    cnt = 16'd3;
    for (int n = 0; n < 70000; n++) begin
      if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
      step(1,0,1,0,3'd0,16'h0000,16'h9000, 0,0, 16'h0000,16'hFFFE,16'h8000,1,cnt);
    end
    // Reset mid-stall, then first edge after release advances from PC_RESET.
    step(0,0,1,0,3'd0,16'h0000,16'h9000, 0,0, 16'h0000,16'h0000,16'h0000,0,16'd0);
    step(1,0,0,0,3'd0,16'h0002,16'h9000, 0,1, 16'h0002,16'h0000,16'h9000,1,16'd0);
    step(1,0,0,0,3'd0,16'h0004,16'hA000, 0,0, 16'h0004,16'h0002,16'hA000,1,16'd0);
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
